// File: rtl/logic_result_stage.sv
// logic_result_stage: registered output stage behind the 32-bit logic unit.
// The stage captures the combinational result and its op tag into a small
// circular FIFO and computes the status flags when it captures them. The
// consumer sees registered head-entry values, so consumer stalls never reach
// back into the logic unit. A wrapping counter of delivered results is kept
// for debug and performance monitoring.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Upstream: push = in_valid & in_ready. Downstream:
// pop = out_valid & out_ready. in_ready depends only on registered state.
// out_* hold steady while out_valid=1 and out_ready=0. A producer that sees
// in_ready=0 must hold in_g/in_op until the stage accepts them. Offering data
// while in_ready=0 sets the sticky overflow flag.
module logic_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_g,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // Pointers carry one extra wrap bit. Equal pointers mean empty. Pointers
  // that differ only in the wrap bit mean full.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_OCC = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_data   [DEPTH];
  logic [1:0]       mem_op     [DEPTH];
  logic             mem_zero   [DEPTH];
  logic             mem_neg    [DEPTH];
  logic             mem_parity [DEPTH];

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   occ;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Occupancy and handshake qualifiers, derived only from the registered pointers
  always_comb begin
    occ       = wr_ptr - rd_ptr;
    full      = (occ == DEPTH_OCC);
    empty     = (occ == '0);
    wr_idx    = wr_ptr[AW-1:0];
    rd_idx    = rd_ptr[AW-1:0];
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Capture the result with its flags. The flags are computed here, at push time,
  // so that the output side only reads the stored entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_idx]   <= in_g;
      mem_op[wr_idx]     <= in_op;
      mem_zero[wr_idx]   <= (in_g == '0);
      mem_neg[wr_idx]    <= in_g[WIDTH-1];
      mem_parity[wr_idx] <= ^in_g;
    end
  end

  // Advance the pointers. A full FIFO only pops because in_ready is low that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Count delivered results. The counter wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (pop) count <= count + 1'b1;
  end

  // Sticky flag for a producer that offers data while the stage is full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
  end

  // Present the head entry. The outputs read zero while empty, so an async
  // reset clears the outputs immediately without having to reset the storage.
  always_comb begin
    out_data   = '0;
    out_op     = '0;
    out_zero   = 1'b0;
    out_neg    = 1'b0;
    out_parity = 1'b0;
    if (!empty) begin
      out_data   = mem_data[rd_idx];
      out_op     = mem_op[rd_idx];
      out_zero   = mem_zero[rd_idx];
      out_neg    = mem_neg[rd_idx];
      out_parity = mem_parity[rd_idx];
    end
  end

endmodule

// File: tb/tb_logic_result_stage.sv
// Testbench for logic_result_stage. A queue-based FIFO model of results and op
// tags supplies the expected values. A second instance with a 4-bit counter,
// driven by the same inputs, covers counter wrap.
module tb_logic_result_stage;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_g;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_op;
  logic             out_zero;
  logic             out_neg;
  logic             out_parity;
  logic [15:0]      count;
  logic             overflow;

  logic             c4_in_ready;
  logic             c4_out_valid;
  logic [WIDTH-1:0] c4_out_data;
  logic [1:0]       c4_out_op;
  logic             c4_out_zero;
  logic             c4_out_neg;
  logic             c4_out_parity;
  logic [3:0]       c4_count;
  logic             c4_overflow;

  always #5 clk = ~clk;

  logic_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_g(in_g), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op), .out_zero(out_zero),
    .out_neg(out_neg), .out_parity(out_parity), .count(count),
    .overflow(overflow)
  );

  logic_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready),
    .in_g(in_g), .in_op(in_op), .out_valid(c4_out_valid), .out_ready(out_ready),
    .out_data(c4_out_data), .out_op(c4_out_op), .out_zero(c4_out_zero),
    .out_neg(c4_out_neg), .out_parity(c4_out_parity), .count(c4_count),
    .overflow(c4_overflow)
  );

  // ---------------- scoreboard / model ----------------
  logic [WIDTH+1:0] exp_q[$];   // {op, data}, oldest entry at index 0
  int unsigned      m_count;
  logic             m_ovf;
  int               checks;
  int               failures;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  // Compare every observable output with the model state before the next edge
  task automatic check_outputs();
    logic [WIDTH-1:0] hd;
    logic [1:0]       hop;
    chk("in_ready",  {63'd0, in_ready},  {63'd0, exp_q.size() < DEPTH});
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      hd  = exp_q[0][WIDTH-1:0];
      hop = exp_q[0][WIDTH+1:WIDTH];
    end else begin
      hd  = '0;
      hop = '0;
    end
    chk("out_data",   64'(out_data), 64'(hd));
    chk("out_op",     64'(out_op),   64'(hop));
    chk("out_zero",   64'(out_zero),   64'((exp_q.size() > 0) && (hd == 0)));
    chk("out_neg",    64'(out_neg),    64'((exp_q.size() > 0) && (hd >= 32'h8000_0000)));
    chk("out_parity", 64'(out_parity), 64'((exp_q.size() > 0) && (($countones(hd) % 2) == 1)));
    chk("count",      64'(count),    64'(m_count % 65536));
    chk("count_c4",   64'(c4_count), 64'(m_count % 16));
    chk("overflow",   64'(overflow), 64'(m_ovf));
  endtask

  // ---------------- driver ----------------
  // Apply the inputs just after a falling edge, check the outputs, update the
  // model for the rising edge, and return at the next falling edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] g,
                      input logic [1:0] op, input logic r, output logic accepted);
    logic can_push;
    logic do_pop;
    in_valid  = v;
    in_g      = g;
    in_op     = op;
    out_ready = r;
    #1;
    check_outputs();
    can_push = exp_q.size() < DEPTH;
    do_pop   = (exp_q.size() > 0) && r;
    accepted = v && can_push;
    if (v && !can_push) m_ovf = 1'b1;
    if (do_pop) begin
      void'(exp_q.pop_front());
      m_count++;
    end
    if (accepted) exp_q.push_back({op, g});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  logic             acc;
  logic             pend;
  logic [WIDTH-1:0] pg;
  logic [1:0]       pop_t;

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_g      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset state and a single pass through the stage
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    step(1'b1, 32'h0000_0000, 2'b00, 1'b0, acc);
    #1;
    chk("single_zero", 64'(out_zero), 64'd1);
    step(1'b0, '0, 2'b00, 1'b1, acc);
    #1;
    chk("single_count", 64'(count), 64'd1);
    chk("single_empty", 64'(out_valid), 64'd0);

    // Flag patterns: negative with even parity, then odd parity
    step(1'b1, 32'h8000_0001, 2'b11, 1'b0, acc);
    #1;
    chk("flag_neg", 64'(out_neg), 64'd1);
    chk("flag_par_even", 64'(out_parity), 64'd0);
    step(1'b1, 32'h0000_0007, 2'b01, 1'b1, acc);
    #1;
    chk("flag_par_odd", 64'(out_parity), 64'd1);
    step(1'b0, '0, 2'b00, 1'b1, acc);

    // Fill and backpressure: 0xC is held until the stage accepts it
    step(1'b1, 32'hA, 2'b00, 1'b0, acc);
    step(1'b1, 32'hB, 2'b01, 1'b0, acc);
    step(1'b1, 32'hC, 2'b10, 1'b0, acc);
    #1;
    chk("bp_overflow", 64'(overflow), 64'd1);
    chk("bp_head_a",   64'(out_data), 64'hA);
    step(1'b1, 32'hC, 2'b10, 1'b0, acc);
    step(1'b1, 32'hC, 2'b10, 1'b1, acc);   // full: pop only
    chk("bp_full_no_push", 64'(acc), 64'd0);
    step(1'b1, 32'hC, 2'b10, 1'b1, acc);   // pop B, push C
    chk("bp_c_accepted", 64'(acc), 64'd1);
    step(1'b0, '0, 2'b00, 1'b1, acc);

    // Async reset between edges with two entries held
    step(1'b1, 32'hD, 2'b00, 1'b0, acc);
    step(1'b1, 32'hE, 2'b00, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_count",     64'(count),     64'd0);
    chk("arst_overflow",  64'(overflow),  64'd0);
    chk("arst_out_data",  64'(out_data),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Streaming: 100 back-to-back pushes with an incrementing payload
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 32'(i + 1), 2'(i), 1'b1, acc);
      if (i > 0) chk("stream_no_bubble", 64'(acc), 64'd1);
    end
    step(1'b0, '0, 2'b00, 1'b1, acc);
    #1;
    chk("stream_count",    64'(count),    64'd100);
    chk("stream_count_c4", 64'(c4_count), 64'd4);

    // Counter wrap on the 4-bit instance: 17 pops leave count at 1
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b1, $urandom, 2'(i), 1'b1, acc);
    step(1'b0, '0, 2'b00, 1'b1, acc);
    #1;
    chk("wrap_count_c4", 64'(c4_count), 64'd1);

    // Randomized traffic; the producer holds data that was not accepted
    do_reset();
    pend = 1'b0;
    pg   = '0;
    pop_t = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        pend  = ($urandom_range(0, 3) != 0);
        pg    = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
        pop_t = 2'($urandom_range(0, 3));
      end
      step(pend, pg, pop_t, ($urandom_range(0, 2) != 0), acc);
      if (acc) pend = 1'b0;
    end
    step(1'b0, '0, 2'b00, 1'b1, acc);
    step(1'b0, '0, 2'b00, 1'b1, acc);
    step(1'b0, '0, 2'b00, 1'b1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so that the run always terminates
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
